hilo_unit: RTL

HILO_UNIT -- requirements
Module: hilo_unit

---
 rtl/hilo_pkg.sv | 19 +
 rtl/hilo_if.sv | 53 +++++
 rtl/hilo_pend_ctr.sv | 63 ++++++
 rtl/hilo_unit.sv | 94 +++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO register unit: widths, select encodings
// and the write-source enumeration.
package hilo_pkg;

  localparam int WORD_W       = 32;
  localparam int PEND_MAX_DEF = 7;
  localparam int PEND_W       = 3;

  localparam logic HILO_SEL_LO = 1'b0;
  localparam logic HILO_SEL_HI = 1'b1;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_MUL,
    SRC_DIV,
    SRC_MT
  } hilo_src_e;

endpackage

// File: rtl/hilo_if.sv
// Bundle of every HI/LO unit signal except clock and reset. The master side
// is the pipeline that issues operations; the slave side is hilo_unit.
interface hilo_if
  import hilo_pkg::*;
#(
  parameter int WORD_W = hilo_pkg::WORD_W
);

  logic              flush;
  logic              mul_issue;
  logic              mul_valid;
  logic [WORD_W-1:0] mul_hi;
  logic [WORD_W-1:0] mul_lo;
  logic              div_issue;
  logic              div_valid;
  logic [WORD_W-1:0] div_q;
  logic [WORD_W-1:0] div_r;
  logic              mt_en;
  logic              mt_sel;
  logic [WORD_W-1:0] mt_data;
  logic              mf_req;
  logic              mf_sel;

  logic              issue_ready;
  logic              mt_ready;
  logic              mf_ready;
  logic [WORD_W-1:0] mf_data;
  logic [WORD_W-1:0] hi;
  logic [WORD_W-1:0] lo;
  logic [PEND_W-1:0] pend_cnt;
  logic              order_err;

  modport master (
    output flush,
    output mul_issue, mul_valid, mul_hi, mul_lo,
    output div_issue, div_valid, div_q, div_r,
    output mt_en, mt_sel, mt_data,
    output mf_req, mf_sel,
    input  issue_ready, mt_ready, mf_ready, mf_data,
    input  hi, lo, pend_cnt, order_err
  );

  modport slave (
    input  flush,
    input  mul_issue, mul_valid, mul_hi, mul_lo,
    input  div_issue, div_valid, div_q, div_r,
    input  mt_en, mt_sel, mt_data,
    input  mf_req, mf_sel,
    output issue_ready, mt_ready, mf_ready, mf_data,
    output hi, lo, pend_cnt, order_err
  );

endinterface

// File: rtl/hilo_pend_ctr.sv
// Outstanding mul/div bookkeeping: counts issues against result strobes,
// gates new issues at the limit and flags ordering violations.
module hilo_pend_ctr
  import hilo_pkg::*;
#(
  parameter int PEND_MAX = PEND_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              mul_issue,
  input  logic              div_issue,
  input  logic              mul_valid,
  input  logic              div_valid,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              issue_ready,
  output logic              res_ok,
  output logic              err_set
);

  logic              issue_req;
  logic              issue_ok;
  logic              any_valid;
  logic              dual_valid;
  logic              cnt_zero;
  logic [PEND_W-1:0] dec;
  logic [PEND_W-1:0] after_dec;
  logic [PEND_W-1:0] cnt_nxt;

  assign issue_req   = mul_issue || div_issue;
  assign any_valid   = mul_valid || div_valid;
  assign dual_valid  = mul_valid && div_valid;
  assign cnt_zero    = (pend_cnt == '0);
  assign issue_ready = (pend_cnt != PEND_W'(PEND_MAX));

  // A flush kills both sides of the accounting for this cycle.
  assign issue_ok = issue_req && issue_ready && !flush;
  assign res_ok   = any_valid && !cnt_zero && !flush;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    dec = '0;
    if (res_ok) dec = dual_valid ? PEND_W'(2) : PEND_W'(1);
  end

  // Saturate against the old count first, then add the new issue, so a
  // stray strobe cannot swallow a same-cycle issue.
  assign after_dec = (dec > pend_cnt) ? '0 : pend_cnt - dec;
  assign cnt_nxt   = flush ? '0 : after_dec + PEND_W'(issue_ok);

  assign err_set = !flush && ((issue_req && !issue_ready) ||
                              (any_valid && cnt_zero)     ||
                              dual_valid);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) pend_cnt <= '0;
    else       pend_cnt <= cnt_nxt;
  end

endmodule

// File: rtl/hilo_unit.sv
// Architectural HI/LO registers with MUL/DIV/MT write paths and zero-latency
// forwarding onto the MF read port.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int WORD_W   = hilo_pkg::WORD_W,
  parameter int PEND_MAX = PEND_MAX_DEF
) (
  input  logic  clk,
  input  logic  reset,
  hilo_if.slave bus
);

  logic [WORD_W-1:0] hi_q;
  logic [WORD_W-1:0] lo_q;
  logic [WORD_W-1:0] hi_nxt;
  logic [WORD_W-1:0] lo_nxt;
  logic [PEND_W-1:0] pend_cnt;
  logic              order_err_q;
  logic              res_ok;
  logic              err_set;
  logic              mt_ok;
  hilo_src_e         src;

  hilo_pend_ctr #(
    .PEND_MAX (PEND_MAX)
  ) u_pend_ctr (
    .clk         (clk),
    .reset       (reset),
    .flush       (bus.flush),
    .mul_issue   (bus.mul_issue),
    .div_issue   (bus.div_issue),
    .mul_valid   (bus.mul_valid),
    .div_valid   (bus.div_valid),
    .pend_cnt    (pend_cnt),
    .issue_ready (bus.issue_ready),
    .res_ok      (res_ok),
    .err_set     (err_set)
  );

  assign bus.mt_ready = (pend_cnt == '0);
  assign mt_ok        = bus.mt_en && bus.mt_ready && !bus.flush;

  // On a double strobe the MUL result wins; the DIV result is dropped.
  always_comb begin
    src = SRC_NONE;
    if (res_ok)     src = bus.mul_valid ? SRC_MUL : SRC_DIV;
    else if (mt_ok) src = SRC_MT;
  end

  always_comb begin
    hi_nxt = hi_q;
    lo_nxt = lo_q;
    unique case (src)
      SRC_MUL: begin
        hi_nxt = bus.mul_hi;
        lo_nxt = bus.mul_lo;
      end
      SRC_DIV: begin
        hi_nxt = bus.div_r;
        lo_nxt = bus.div_q;
      end
      SRC_MT: begin
        if (bus.mt_sel == HILO_SEL_HI) hi_nxt = bus.mt_data;
        else                           lo_nxt = bus.mt_data;
      end
      default: ;
    endcase
  end

  // Reading the next-state value gives result > MT > stored priority for free.
  assign bus.mf_ready = bus.mf_req &&
                        ((pend_cnt == '0) || ((pend_cnt == PEND_W'(1)) && res_ok));
  assign bus.mf_data  = !bus.mf_ready ? '0 :
                        (bus.mf_sel == HILO_SEL_HI) ? hi_nxt : lo_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q        <= '0;
      lo_q        <= '0;
      order_err_q <= 1'b0;
    end else begin
      hi_q <= hi_nxt;
      lo_q <= lo_nxt;
      if (err_set) order_err_q <= 1'b1;
    end
  end

  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.pend_cnt  = pend_cnt;
  assign bus.order_err = order_err_q;

endmodule
